alu_mc_param: RTL and testbench

//  Parametrised multi-cycle ALU for the datapath: WIDTH-bit operands, registered result and flags.

---
 rtl/alu_mc_param.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_mc_param.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mc_param.sv
// Multi-cycle ALU: single-cycle logic/arithmetic, iterative shifts (1 bit/cycle) and shift-add
// multiply, with registered result/flags and a START/BUSY/DONE handshake.
module alu_mc_param #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_inputa,
    input  logic [WIDTH-1:0] i_inputb,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_out,
    output logic             o_cf,
    output logic             o_zf,
    output logic             o_br_flag
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StMul,
        StFin
    } state_t;

    localparam logic [3:0] OpAdd   = 4'd0;
    localparam logic [3:0] OpAdc   = 4'd1;
    localparam logic [3:0] OpSub   = 4'd2;
    localparam logic [3:0] OpXor   = 4'd3;
    localparam logic [3:0] OpNot   = 4'd4;
    localparam logic [3:0] OpSra   = 4'd5;
    localparam logic [3:0] OpSrl   = 4'd6;
    localparam logic [3:0] OpSll   = 4'd7;
    localparam logic [3:0] OpMul   = 4'd8;
    localparam logic [3:0] OpCmplt = 4'd9;
    localparam logic [3:0] OpCmpmh = 4'd10;

    localparam logic [SHW:0] CntOne = (SHW+1)'(1);
    localparam logic [SHW:0] CntMul = (SHW+1)'(WIDTH);

    state_t             r_state;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_work;
    logic [2*WIDTH-1:0] r_acc;
    logic [SHW:0]       r_cnt;
    logic [WIDTH-1:0]   r_out;
    logic               r_cf;
    logic               r_zf;
    logic               r_br;

    state_t             w_state;
    logic [3:0]         w_op;
    logic [WIDTH-1:0]   w_mcand;
    logic [WIDTH-1:0]   w_work;
    logic [2*WIDTH-1:0] w_acc;
    logic [SHW:0]       w_cnt;
    logic [WIDTH-1:0]   w_out;
    logic               w_cf;
    logic               w_zf;
    logic               w_br;
    logic               w_out_upd;

    logic               w_accept;
    logic [SHW-1:0]     w_n;
    logic               w_cin;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_shift_val;
    logic               w_shift_bit;
    logic [WIDTH:0]     w_mul_hi;
    logic [2*WIDTH-1:0] w_mul_val;

    assign w_accept = i_start && (r_state == StIdle || r_state == StFin);
    assign w_n      = i_inputb[SHW-1:0];
    assign w_cin    = (i_op == OpAdc) && r_cf;
    assign w_sum    = {1'b0, i_inputa} + {1'b0, i_inputb} + {{WIDTH{1'b0}}, w_cin};

    // One shift step on the working register; the bit falling off becomes CF on the last step.
    always_comb begin
        w_shift_val = {1'b0, r_work[WIDTH-1:1]};
        w_shift_bit = r_work[0];
        case (r_op)
            OpSra: w_shift_val = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            OpSll: begin
                w_shift_val = {r_work[WIDTH-2:0], 1'b0};
                w_shift_bit = r_work[WIDTH-1];
            end
            default: ;
        endcase
    end

    // Shift-add step: multiplier sits in the low half and is consumed LSB first.
    assign w_mul_hi  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_mul_val = {w_mul_hi, r_acc[WIDTH-1:1]};

    always_comb begin
        w_state   = r_state;
        w_op      = r_op;
        w_mcand   = r_mcand;
        w_work    = r_work;
        w_acc     = r_acc;
        w_cnt     = r_cnt;
        w_out     = r_out;
        w_cf      = r_cf;
        w_br      = r_br;
        w_out_upd = 1'b0;

        case (r_state)
            StIdle, StFin: begin
                if (w_accept) begin
                    w_op    = i_op;
                    w_state = StFin;
                    case (i_op)
                        OpAdd, OpAdc: begin
                            {w_cf, w_out} = w_sum;
                            w_out_upd     = 1'b1;
                        end
                        OpSub: begin
                            w_out     = i_inputa - i_inputb;
                            w_cf      = (i_inputa < i_inputb);
                            w_out_upd = 1'b1;
                        end
                        OpXor: begin
                            w_out     = i_inputa ^ i_inputb;
                            w_out_upd = 1'b1;
                        end
                        OpNot: begin
                            w_out     = ~i_inputb;
                            w_out_upd = 1'b1;
                        end
                        OpSra, OpSrl, OpSll: begin
                            if (w_n == '0) begin
                                w_out     = i_inputa;
                                w_out_upd = 1'b1;
                            end else begin
                                w_work  = i_inputa;
                                w_cnt   = {1'b0, w_n};
                                w_state = StShift;
                            end
                        end
                        OpMul: begin
                            w_mcand = i_inputa;
                            w_acc   = {{WIDTH{1'b0}}, i_inputb};
                            w_cnt   = CntMul;
                            w_state = StMul;
                        end
                        OpCmplt: w_br = ($signed(i_inputa) < $signed(i_inputb));
                        OpCmpmh: w_br = (i_inputa[WIDTH-1:WIDTH/2] == i_inputb[WIDTH-1:WIDTH/2]);
                        default: begin
                            w_out     = '0;
                            w_out_upd = 1'b1;
                        end
                    endcase
                end else if (r_state == StFin) begin
                    w_state = StIdle;
                end
            end
            StShift: begin
                w_work = w_shift_val;
                w_cnt  = r_cnt - CntOne;
                if (r_cnt == CntOne) begin
                    w_out     = w_shift_val;
                    w_cf      = w_shift_bit;
                    w_out_upd = 1'b1;
                    w_state   = StFin;
                end
            end
            StMul: begin
                w_acc = w_mul_val;
                w_cnt = r_cnt - CntOne;
                if (r_cnt == CntOne) begin
                    w_out     = w_mul_val[WIDTH-1:0];
                    w_cf      = |w_mul_val[2*WIDTH-1:WIDTH];
                    w_out_upd = 1'b1;
                    w_state   = StFin;
                end
            end
            default: w_state = StIdle;
        endcase

        w_zf = w_out_upd ? (w_out == '0) : r_zf;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_op    <= '0;
            r_mcand <= '0;
            r_work  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_cf    <= 1'b0;
            r_zf    <= 1'b0;
            r_br    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_op    <= w_op;
            r_mcand <= w_mcand;
            r_work  <= w_work;
            r_acc   <= w_acc;
            r_cnt   <= w_cnt;
            r_out   <= w_out;
            r_cf    <= w_cf;
            r_zf    <= w_zf;
            r_br    <= w_br;
        end
    end

    assign o_busy    = (r_state == StShift) || (r_state == StMul);
    assign o_done    = (r_state == StFin);
    assign o_out     = r_out;
    assign o_cf      = r_cf;
    assign o_zf      = r_zf;
    assign o_br_flag = r_br;

endmodule

// File: tb/tb_alu_mc_param.sv
// Directed self-checking bench for alu_mc_param (WIDTH=8) with hand-computed expectations.
module tb_alu_mc_param;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         cf;
    logic         zf;
    logic         br;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mc_param #(.WIDTH(W)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_start   (start),
        .i_op      (op),
        .i_inputa  (a),
        .i_inputb  (b),
        .o_busy    (busy),
        .o_done    (done),
        .o_out     (out),
        .o_cf      (cf),
        .o_zf      (zf),
        .o_br_flag (br)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge, then wait (bounded) for DONE, checking latency, BUSY length
    // and that OUT holds while busy.
    task automatic run(input string tag, input logic [3:0] o, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input int exp_lat, input int exp_busy);
        logic [W-1:0] held;
        int lat;
        int nb;
        held  = out;
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        nb    = 0;
        while (!done && lat < 40) begin
            if (busy) begin
                nb++;
                chk({tag, "_hold"}, 32'(out), 32'(held));
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, nb, exp_busy);
    endtask

    task automatic chk_res(input string tag, input logic [W-1:0] eo, input logic ec,
                           input logic ez, input logic eb);
        chk({tag, "_out"}, 32'(out), 32'(eo));
        chk({tag, "_cf"}, 32'(cf), 32'(ec));
        chk({tag, "_zf"}, 32'(zf), 32'(ez));
        chk({tag, "_br"}, 32'(br), 32'(eb));
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk_res("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        reset = 1'b0;
        @(negedge clk);

        // Carry chain: ADD then ADC consumes CF, issued back to back from FIN.
        run("add", 4'd0, 8'hF0, 8'h20, 1, 0);
        chk_res("add", 8'h10, 1'b1, 1'b0, 1'b0);
        run("adc", 4'd1, 8'h01, 8'h01, 1, 0);
        chk_res("adc", 8'h03, 1'b0, 1'b0, 1'b0);
        run("sub", 4'd2, 8'h05, 8'h07, 1, 0);
        chk_res("sub", 8'hFE, 1'b1, 1'b0, 1'b0);
        run("rsv", 4'd12, 8'h12, 8'h34, 1, 0);
        chk_res("rsv", 8'h00, 1'b1, 1'b1, 1'b0);
        run("srl0", 4'd6, 8'h5A, 8'h00, 1, 0);
        chk_res("srl0", 8'h5A, 1'b1, 1'b0, 1'b0);
        run("xor", 4'd3, 8'h5A, 8'h5A, 1, 0);
        chk_res("xor", 8'h00, 1'b1, 1'b1, 1'b0);
        run("not", 4'd4, 8'h00, 8'h0F, 1, 0);
        chk_res("not", 8'hF0, 1'b1, 1'b0, 1'b0);

        run("sll", 4'd7, 8'h81, 8'h03, 4, 3);
        chk_res("sll", 8'h08, 1'b0, 1'b0, 1'b0);
        run("sra", 4'd5, 8'h80, 8'h07, 8, 7);
        chk_res("sra", 8'hFF, 1'b0, 1'b0, 1'b0);
        run("srl", 4'd6, 8'h81, 8'h01, 2, 1);
        chk_res("srl", 8'h40, 1'b1, 1'b0, 1'b0);

        run("mul1", 4'd8, 8'h0D, 8'h0B, 9, 8);
        chk_res("mul1", 8'h8F, 1'b0, 1'b0, 1'b0);
        run("mul2", 4'd8, 8'h14, 8'h14, 9, 8);
        chk_res("mul2", 8'h90, 1'b1, 1'b0, 1'b0);

        run("cmplt", 4'd9, 8'hFE, 8'h01, 1, 0);
        chk_res("cmplt", 8'h90, 1'b1, 1'b0, 1'b1);
        run("cmpmh1", 4'd10, 8'hA5, 8'hAF, 1, 0);
        chk_res("cmpmh1", 8'h90, 1'b1, 1'b0, 1'b1);
        run("cmpmh2", 4'd10, 8'hA5, 8'hB5, 1, 0);
        chk_res("cmpmh2", 8'h90, 1'b1, 1'b0, 1'b0);

        // START while busy must be dropped, not queued.
        start = 1'b1;
        op    = 4'd8;
        a     = 8'h03;
        b     = 8'h05;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        op    = 4'd3;
        a     = 8'hFF;
        b     = 8'h00;
        @(negedge clk);
        start = 1'b0;
        lat   = 4;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ign_lat", lat, 9);
        chk_res("ign", 8'h0F, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ign_single_done", 32'(done), 0);
        chk("ign_idle_busy", 32'(busy), 0);

        // Reset in the middle of a multiply aborts it.
        start = 1'b1;
        op    = 4'd8;
        a     = 8'hFF;
        b     = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_res("abort", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("abort_done", 32'(done), 0);
        chk("abort_busy", 32'(busy), 0);
        run("post", 4'd0, 8'h01, 8'h02, 1, 0);
        chk_res("post", 8'h03, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_done_clr", 32'(done), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
